// File: rtl/program_sequencer_if.sv
// Sequencer control bundle: host start handshake plus fetch-unit hold/jump controls.
// The sequencer takes the slave modport; the host/fetch side takes the master modport.
interface program_sequencer_if #(
  parameter int PC_W = 10
);
  logic            StartReq;
  logic            HaltDecoded;
  logic            MemBusy;
  logic            PcHold;
  logic            PcLoad;
  logic [PC_W-1:0] PcLoadAddr;
  logic            Running;
  logic            Done;
  logic [1:0]      ProgIdx;
  logic [15:0]     CycleCount;
  logic            Timeout;

  modport master (
    output StartReq, HaltDecoded, MemBusy,
    input  PcHold, PcLoad, PcLoadAddr, Running, Done, ProgIdx, CycleCount, Timeout
  );

  modport slave (
    input  StartReq, HaltDecoded, MemBusy,
    output PcHold, PcLoad, PcLoadAddr, Running, Done, ProgIdx, CycleCount, Timeout
  );
endinterface

// File: rtl/program_sequencer.sv
// Program-run sequencer: holds fetch idle, loads a program base, free-runs until halt.
// Optional RUN-cycle watchdog is built only when SEQ_WATCHDOG_EN is defined.
//
// state | meaning
// IDLE  | PC held, waiting for a StartReq rising edge
// LOAD  | one cycle, PC forced to the selected program base
// RUN   | fetch free-runs, stalled by MemBusy, counts cycles
// DONE  | program finished (halt or watchdog), PC held, ProgIdx advanced
module program_sequencer #(
  parameter int              PC_W       = 10,
  parameter int              NUM_PROGS  = 3,
  parameter logic [PC_W-1:0] PROG0_BASE = 10'd0,
  parameter logic [PC_W-1:0] PROG1_BASE = 10'd128,
  parameter logic [PC_W-1:0] PROG2_BASE = 10'd256,
  parameter logic [15:0]     WDOG_LIMIT = 16'd4000
) (
  input  logic clock,
  input  logic Reset,
  program_sequencer_if.slave seq
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic            start_q;
  logic            start_armed;
  logic            start_rise;
  logic            halt_taken;
  logic            wdog_hit;
  logic [1:0]      prog_idx;
  logic [1:0]      prog_idx_nxt;
  logic [15:0]     cycle_count;
  logic [PC_W-1:0] load_addr;
  logic            pc_hold, pc_load, running, done;

  // A level already high when reset releases is not an edge; arm only after seeing it low.
  assign start_rise = seq.StartReq & ~start_q & start_armed;
  assign halt_taken = seq.HaltDecoded & ~seq.MemBusy;
  assign prog_idx_nxt = (prog_idx == 2'(NUM_PROGS - 1)) ? 2'd0 : prog_idx + 2'd1;

`ifdef SEQ_WATCHDOG_EN
  logic timeout_q;
  assign wdog_hit = (cycle_count == WDOG_LIMIT - 16'd1);
`else
  assign wdog_hit = 1'b0;
`endif

  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      state       <= IDLE;
      start_q     <= 1'b0;
      start_armed <= 1'b0;
      prog_idx    <= 2'd0;
      cycle_count <= 16'd0;
`ifdef SEQ_WATCHDOG_EN
      timeout_q   <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      start_q <= seq.StartReq;
      if (!seq.StartReq) start_armed <= 1'b1;

      if (state == LOAD) cycle_count <= 16'd0;
      else if (state == RUN && cycle_count != 16'hFFFF) cycle_count <= cycle_count + 16'd1;

      if (state == RUN && state_nxt == DONE) prog_idx <= prog_idx_nxt;

`ifdef SEQ_WATCHDOG_EN
      if (state == LOAD) timeout_q <= 1'b0;
      else if (state == RUN && state_nxt == DONE) timeout_q <= ~halt_taken;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    pc_hold   = 1'b1;
    pc_load   = 1'b0;
    running   = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start_rise) state_nxt = LOAD;
      end
      LOAD: begin
        pc_hold   = 1'b0;
        pc_load   = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        running = 1'b1;
        // A pending halt keeps the PC parked on the halt instruction even while busy.
        pc_hold = seq.MemBusy | seq.HaltDecoded;
        if (halt_taken || wdog_hit) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start_rise) state_nxt = LOAD;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    load_addr = PROG0_BASE;
    case (prog_idx)
      2'd0:    load_addr = PROG0_BASE;
      2'd1:    load_addr = PROG1_BASE;
      default: load_addr = PROG2_BASE;
    endcase
  end

  assign seq.PcHold     = pc_hold;
  assign seq.PcLoad     = pc_load;
  assign seq.PcLoadAddr = load_addr;
  assign seq.Running    = running;
  assign seq.Done       = done;
  assign seq.ProgIdx    = prog_idx;
  assign seq.CycleCount = cycle_count;
`ifdef SEQ_WATCHDOG_EN
  assign seq.Timeout    = timeout_q;
`else
  assign seq.Timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_program_sequencer.sv
// Scoreboard bench for program_sequencer: stimulus queues expected load/done events,
// a negedge monitor pops and compares them as the DUT presents PcLoad or a Done edge.
module tb_program_sequencer;

  logic clock = 1'b0;
  logic Reset;
  always #5 clock = ~clock;

  program_sequencer_if #(.PC_W(10)) sif ();

  program_sequencer #(
    .PC_W(10), .NUM_PROGS(3),
    .PROG0_BASE(10'd0), .PROG1_BASE(10'd128), .PROG2_BASE(10'd256),
    .WDOG_LIMIT(16'd50)
  ) dut (
    .clock(clock),
    .Reset(Reset),
    .seq(sif)
  );

  typedef struct {
    bit          is_done;
    logic [9:0]  addr;
    logic [1:0]  idx;
    logic [15:0] cnt;
    logic        tmo;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic done_d;
  logic [1:0] exp_idx;
  logic [9:0] bases [3];

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Monitor: consumes one scoreboard entry per PcLoad cycle and per Done rising edge.
  always @(negedge clock) begin
    exp_t e;
    if (sif.PcLoad === 1'b1) begin
      if (sb.size() == 0 || sb[0].is_done) begin
        n_cmp++; n_bad++;
        $display("FAIL load_event: unexpected PcLoad with addr %0d idx %0d", sif.PcLoadAddr, sif.ProgIdx);
      end else begin
        e = sb.pop_front();
        check("load_addr", 32'(sif.PcLoadAddr), 32'(e.addr));
        check("load_idx", 32'(sif.ProgIdx), 32'(e.idx));
        check("load_hold", 32'(sif.PcHold), 32'd0);
      end
    end
    if (sif.Done === 1'b1 && done_d !== 1'b1) begin
      if (sb.size() == 0 || !sb[0].is_done) begin
        n_cmp++; n_bad++;
        $display("FAIL done_event: unexpected Done with count %0d idx %0d", sif.CycleCount, sif.ProgIdx);
      end else begin
        e = sb.pop_front();
        check("done_count", 32'(sif.CycleCount), 32'(e.cnt));
        check("done_idx", 32'(sif.ProgIdx), 32'(e.idx));
        check("done_timeout", 32'(sif.Timeout), 32'(e.tmo));
        check("done_hold", 32'(sif.PcHold), 32'd1);
      end
    end
    done_d <= sif.Done;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start_pulse();
    sif.StartReq = 1'b0;
    tick();
    sif.StartReq = 1'b1;
    tick();
  endtask

  task automatic wait_running(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (sif.Running === 1'b1) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
  endtask

  function automatic logic [1:0] next_idx(logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  // n RUN cycles with halt in the nth; busy_test fixes n at 8 with a 5-cycle stall.
  task automatic run_prog(input int n, input bit busy_test, input bit spurious);
    bit ok;
    sb.push_back('{1'b0, bases[exp_idx], exp_idx, 16'd0, 1'b0});
    sb.push_back('{1'b1, 10'd0, next_idx(exp_idx), 16'(n), 1'b0});
    start_pulse();
    wait_running(ok);
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL run_entry: Running never rose, got %0d expected 1", sif.Running);
      return;
    end
    check("run_count_start", 32'(sif.CycleCount), 32'd0);
    check("run_timeout_clear", 32'(sif.Timeout), 32'd0);
    if (busy_test) begin
      tick(); tick();
      for (int i = 0; i < 5; i++) begin
        sif.MemBusy = 1'b1;
        sif.HaltDecoded = (i == 4);
        #2;
        check("busy_hold", 32'(sif.PcHold), 32'd1);
        check("busy_running", 32'(sif.Running), 32'd1);
        tick();
      end
      sif.MemBusy = 1'b0;
      sif.HaltDecoded = 1'b1;
      #2;
      check("busy_still_run", 32'(sif.Running), 32'd1);
    end else begin
      for (int c = 1; c < n; c++) begin
        if (spurious && c == 2) sif.StartReq = 1'b0;
        if (spurious && c == 3) sif.StartReq = 1'b1;
        tick();
      end
      #2;
      check("run_free_hold", 32'(sif.PcHold), 32'd0);
      sif.HaltDecoded = 1'b1;
      #1;
      check("halt_hold", 32'(sif.PcHold), 32'd1);
    end
    tick();
    sif.HaltDecoded = 1'b0;
    check("done_state", 32'(sif.Done), 32'd1);
    exp_idx = next_idx(exp_idx);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, expected finish", $time);
    $fatal(1, "bench time limit reached");
  end

  initial begin
    bit ok;
    bases[0] = 10'd0; bases[1] = 10'd128; bases[2] = 10'd256;
    exp_idx = 2'd0;
    Reset = 1'b0;
    sif.StartReq = 1'b1;
    sif.HaltDecoded = 1'b0;
    sif.MemBusy = 1'b0;
    #3;
    check("rst_hold", 32'(sif.PcHold), 32'd1);
    check("rst_done", 32'(sif.Done), 32'd0);
    check("rst_idx", 32'(sif.ProgIdx), 32'd0);
    check("rst_count", 32'(sif.CycleCount), 32'd0);
    check("rst_load", 32'(sif.PcLoad), 32'd0);
    tick(); tick();
    Reset = 1'b1;
    repeat (5) tick();
    check("idle_no_edge_running", 32'(sif.Running), 32'd0);
    check("idle_no_edge_hold", 32'(sif.PcHold), 32'd1);

    run_prog(20, 1'b0, 1'b0);
    run_prog(5, 1'b0, 1'b1);
    run_prog(8, 1'b1, 1'b0);

`ifdef SEQ_WATCHDOG_EN
    sb.push_back('{1'b0, bases[exp_idx], exp_idx, 16'd0, 1'b0});
    sb.push_back('{1'b1, 10'd0, next_idx(exp_idx), 16'd50, 1'b1});
    start_pulse();
    wait_running(ok);
    for (int i = 0; i < 60 && sif.Done !== 1'b1; i++) tick();
    check("wdog_done", 32'(sif.Done), 32'd1);
    exp_idx = next_idx(exp_idx);
    tick();
    run_prog(3, 1'b0, 1'b0);
`endif

    // Reset mid-run: abort with no Done, ProgIdx back to 0.
    sb.push_back('{1'b0, bases[exp_idx], exp_idx, 16'd0, 1'b0});
    start_pulse();
    wait_running(ok);
    check("abort_running", 32'(sif.Running), 32'd1);
    repeat (3) tick();
    Reset = 1'b0;
    #2;
    check("abort_running_low", 32'(sif.Running), 32'd0);
    check("abort_hold", 32'(sif.PcHold), 32'd1);
    check("abort_idx", 32'(sif.ProgIdx), 32'd0);
    check("abort_done", 32'(sif.Done), 32'd0);
    check("abort_count", 32'(sif.CycleCount), 32'd0);
    tick();
    Reset = 1'b1;
    repeat (10) tick();
    check("abort_stays_idle", 32'(sif.Running), 32'd0);
    exp_idx = 2'd0;

    run_prog(1, 1'b0, 1'b0);

    repeat (3) tick();
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
